// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue: default sizes and the
// in-flight branch record layout, packed MSB-first as {pred, idx, fallthru}.
package branch_resolve_queue_pkg;

    localparam int BRQ_DEPTH_DEFAULT = 4;
    localparam int BRQ_IDX_W         = 3;
    localparam int BRQ_PC_W          = 10;

    typedef struct packed {
        logic                 pred;
        logic [BRQ_IDX_W-1:0] idx;
        logic [BRQ_PC_W-1:0]  fallthru;
    } brq_rec_t;

    // Record width for arbitrary field widths, same packing order as brq_rec_t.
    function automatic int brq_rec_width(input int idx_w, input int pc_w);
        return 1 + idx_w + pc_w;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// Circular record buffer: push writes at the tail, rdata always shows the head,
// clear empties it synchronously and takes priority over push/pop.
module brq_fifo
    import branch_resolve_queue_pkg::*;
#(
    parameter int W     = brq_rec_width(BRQ_IDX_W, BRQ_PC_W),
    parameter int DEPTH = BRQ_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail] <= wdata;
    end

    assign rdata = mem[head];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight predicted branches from fetch to EX, emits predictor
// training updates and front-end redirects on misprediction.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int GSHARE_BITS_NUM      = BRQ_IDX_W,
    parameter int OPTION_OPERAND_WIDTH = BRQ_PC_W,
    parameter int DEPTH                = BRQ_DEPTH_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Branch_F,
    input  logic                            stall_F,
    input  logic                            pred_F,
    input  logic [GSHARE_BITS_NUM-1:0]      idx_F,
    input  logic [OPTION_OPERAND_WIDTH-1:0] fallthru_F,
    input  logic                            Branch_EX,
    input  logic                            taken,
    input  logic [OPTION_OPERAND_WIDTH-1:0] target_EX,
    input  logic                            flush_in,
    output logic                            upd_valid,
    output logic                            upd_taken,
    output logic [GSHARE_BITS_NUM-1:0]      upd_idx,
    output logic                            mispredict,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc,
    output logic                            full,
    output logic                            empty,
    output logic                            overflow
);

    localparam int REC_W = brq_rec_width(GSHARE_BITS_NUM, OPTION_OPERAND_WIDTH);

    logic [REC_W-1:0]                wrec;
    logic [REC_W-1:0]                hrec;
    logic                            head_pred;
    logic [GSHARE_BITS_NUM-1:0]      head_idx;
    logic [OPTION_OPERAND_WIDTH-1:0] head_fallthru;
    logic                            push;
    logic                            pop;
    logic                            mispredict_now;
    logic                            clear;
    logic                            ovf_set;

    assign wrec = {pred_F, idx_F, fallthru_F};
    assign {head_pred, head_idx, head_fallthru} = hrec;

    assign pop            = Branch_EX && !empty;
    assign mispredict_now = pop && (taken != head_pred);
    assign push           = Branch_F && !stall_F && !full && !flush_in && !mispredict_now;
    assign clear          = flush_in || mispredict_now;
    assign ovf_set        = (Branch_F && !stall_F && full) || (Branch_EX && empty);

    brq_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wrec),
        .rdata (hrec),
        .full  (full),
        .empty (empty)
    );

    // upd_valid and mispredict are single-cycle strobes with no back-pressure:
    // upd_taken/upd_idx and redirect_pc are meaningful only while their strobe
    // is high and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid   <= 1'b0;
            upd_taken   <= 1'b0;
            upd_idx     <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            overflow    <= 1'b0;
        end else begin
            upd_valid  <= pop;
            mispredict <= mispredict_now;
            overflow   <= overflow | ovf_set;
            if (pop) begin
                upd_taken <= taken;
                upd_idx   <= head_idx;
            end
            if (mispredict_now) begin
                redirect_pc <= taken ? target_EX : head_fallthru;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: expected updates go into a queue
// as each resolve is issued; a monitor pops and compares on every update strobe.
module tb_branch_resolve_queue;

    localparam int G  = 3;
    localparam int O  = 10;
    localparam int D  = 4;
    localparam int EW = 2 + G + O;

    logic         clk;
    logic         rst;
    logic         Branch_F;
    logic         stall_F;
    logic         pred_F;
    logic [G-1:0] idx_F;
    logic [O-1:0] fallthru_F;
    logic         Branch_EX;
    logic         taken;
    logic [O-1:0] target_EX;
    logic         flush_in;
    logic         upd_valid;
    logic         upd_taken;
    logic [G-1:0] upd_idx;
    logic         mispredict;
    logic [O-1:0] redirect_pc;
    logic         full;
    logic         empty;
    logic         overflow;

    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 0;

    branch_resolve_queue #(
        .GSHARE_BITS_NUM      (G),
        .OPTION_OPERAND_WIDTH (O),
        .DEPTH                (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Branch_F    (Branch_F),
        .stall_F     (stall_F),
        .pred_F      (pred_F),
        .idx_F       (idx_F),
        .fallthru_F  (fallthru_F),
        .Branch_EX   (Branch_EX),
        .taken       (taken),
        .target_EX   (target_EX),
        .flush_in    (flush_in),
        .upd_valid   (upd_valid),
        .upd_taken   (upd_taken),
        .upd_idx     (upd_idx),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        if (mon_en) begin
            n_vec++;
            if (upd_valid) begin
                act = {mispredict, upd_taken, upd_idx, mispredict ? redirect_pc : O'(0)};
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_update: got 0x%0h, required no update", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL update {mp,taken,idx,redirect}: got 0x%0h, required 0x%0h", act, e);
                    end
                end
            end else if (mispredict) begin
                n_err++;
                $display("FAIL stray_mispredict: got mispredict=1 without update, required 0");
            end
        end
    end

    // driver tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_upd(input logic mp, input logic tk, input logic [G-1:0] idx,
                              input logic [O-1:0] rpc);
        exp_q.push_back({mp, tk, idx, mp ? rpc : O'(0)});
    endtask

    task automatic step(input logic bf, input logic pf, input logic [G-1:0] fi,
                        input logic [O-1:0] ft, input logic bex, input logic tk,
                        input logic [O-1:0] tgt, input logic fl);
        Branch_F   = bf;
        pred_F     = pf;
        idx_F      = fi;
        fallthru_F = ft;
        Branch_EX  = bex;
        taken      = tk;
        target_EX  = tgt;
        flush_in   = fl;
        @(negedge clk);
        Branch_F   = 1'b0;
        Branch_EX  = 1'b0;
        flush_in   = 1'b0;
    endtask

    task automatic push(input logic pf, input logic [G-1:0] fi, input logic [O-1:0] ft);
        step(1'b1, pf, fi, ft, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic pop(input logic tk, input logic [O-1:0] tgt);
        step(1'b0, 1'b0, '0, '0, 1'b1, tk, tgt, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        Branch_F   = 1'b0;
        stall_F    = 1'b0;
        pred_F     = 1'b0;
        idx_F      = '0;
        fallthru_F = '0;
        Branch_EX  = 1'b0;
        taken      = 1'b0;
        target_EX  = '0;
        flush_in   = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_upd_valid", upd_valid, 0);
        chk("reset_upd_taken", upd_taken, 0);
        chk("reset_upd_idx", upd_idx, 0);
        chk("reset_mispredict", mispredict, 0);
        chk("reset_redirect_pc", redirect_pc, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_overflow", overflow, 0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // correct taken prediction; first push after reset lands at once
        push(1'b1, 3'd5, 10'h010);
        chk("first_push_empty", empty, 0);
        expect_upd(1'b0, 1'b1, 3'd5, '0);
        pop(1'b1, 10'h3ff);
        chk("t1_empty", empty, 1);

        // predicted taken, actually not taken: redirect to fallthru
        push(1'b1, 3'd2, 10'h041);
        expect_upd(1'b1, 1'b0, 3'd2, 10'h041);
        pop(1'b0, 10'h2aa);
        chk("t2_empty", empty, 1);

        // oldest of three mispredicts; younger ones and a same-cycle push vanish
        push(1'b0, 3'd1, 10'h020);
        push(1'b1, 3'd3, 10'h021);
        push(1'b1, 3'd4, 10'h022);
        chk("t3_full", full, 0);
        expect_upd(1'b1, 1'b1, 3'd1, 10'h100);
        step(1'b1, 1'b1, 3'd7, 10'h023, 1'b1, 1'b1, 10'h100, 1'b0);
        chk("t3_empty", empty, 1);
        repeat (2) @(negedge clk);

        // flush with a same-cycle correct pop still emits the update
        push(1'b0, 3'd6, 10'h030);
        push(1'b1, 3'd7, 10'h031);
        expect_upd(1'b0, 1'b0, 3'd6, '0);
        step(1'b1, 1'b0, 3'd2, 10'h032, 1'b1, 1'b0, '0, 1'b1);
        chk("flush_empty", empty, 1);
        chk("flush_overflow", overflow, 0);

        // fill, overflow on a fifth push, drain in order
        push(1'b1, 3'd0, 10'h050);
        push(1'b0, 3'd1, 10'h051);
        push(1'b1, 3'd2, 10'h052);
        push(1'b0, 3'd3, 10'h053);
        chk("fill_full", full, 1);
        chk("fill_overflow", overflow, 0);
        push(1'b1, 3'd7, 10'h054);
        chk("ovf_full", full, 1);
        chk("ovf_overflow", overflow, 1);
        expect_upd(1'b0, 1'b1, 3'd0, '0);
        pop(1'b1, '0);
        expect_upd(1'b0, 1'b0, 3'd1, '0);
        pop(1'b0, '0);
        chk("drain2_full", full, 0);

        // wrap the tail, then simultaneous push/pop across the head wrap
        push(1'b1, 3'd4, 10'h060);
        push(1'b0, 3'd5, 10'h061);
        chk("wrap_full", full, 1);
        expect_upd(1'b0, 1'b1, 3'd2, '0);
        pop(1'b1, '0);
        chk("wrap_pop_full", full, 0);
        expect_upd(1'b0, 1'b0, 3'd3, '0);
        step(1'b1, 1'b1, 3'd6, 10'h062, 1'b1, 1'b0, '0, 1'b0);
        chk("pushpop_full", full, 0);
        chk("pushpop_empty", empty, 0);
        push(1'b1, 3'd1, 10'h063);
        chk("pushpop_refill_full", full, 1);
        expect_upd(1'b0, 1'b1, 3'd4, '0);
        pop(1'b1, '0);
        expect_upd(1'b0, 1'b0, 3'd5, '0);
        pop(1'b0, '0);
        expect_upd(1'b0, 1'b1, 3'd6, '0);
        pop(1'b1, '0);
        expect_upd(1'b0, 1'b1, 3'd1, '0);
        pop(1'b1, '0);
        chk("wrap_drained_empty", empty, 1);

        // asynchronous reset between edges while an update is on the outputs
        push(1'b1, 3'd5, 10'h070);
        push(1'b1, 3'd6, 10'h071);
        expect_upd(1'b0, 1'b1, 3'd5, '0);
        pop(1'b1, '0);
        #2 rst = 1'b0;
        #1;
        chk("async_upd_valid", upd_valid, 0);
        chk("async_upd_taken", upd_taken, 0);
        chk("async_upd_idx", upd_idx, 0);
        chk("async_mispredict", mispredict, 0);
        chk("async_redirect_pc", redirect_pc, 0);
        chk("async_empty", empty, 1);
        chk("async_full", full, 0);
        chk("async_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        pop(1'b1, '0);
        chk("post_reset_pop_overflow", overflow, 1);
        chk("post_reset_pop_empty", empty, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
